uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte transmitter among NUM_REQ requesters.
- Arbitration is round-robin at packet granularity: a requester keeps the transmitter until it sends a byte flagged last.
- Sequences the transmitter's one-cycle uart_tx_en start pulse, then tracks uart_tx_busy to detect byte completion.
- Sits between the per-function byte sources (command responders, status reporters) and the single uart_tx instance feeding uart_txd.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: byte width; must match uart_tx.
- BUSY_WAIT, 16: maximum cycles to wait for uart_tx_busy to rise after a start pulse before declaring a timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester byte valid; must stay high with stable data until the matching req_ready.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  marks the final byte of a packet; qualified by req_valid.
- req_ready  output  NUM_REQ  one-cycle accept strobe per requester, one-hot or zero.
- uart_tx_en  output  1  one-cycle start pulse to uart_tx.
- uart_tx_data  output  DATA_W  byte to uart_tx; stable from the start pulse until the next load.
- uart_tx_busy  input  1  busy flag from uart_tx.
- grant_id  output  clog2(NUM_REQ)  current or last granted requester.
- grant_active  output  1  high while a packet owns the transmitter.
- err_timeout  output  1  one-cycle pulse on a busy timeout.

Behaviour:
- All outputs are registered except req_ready, which is decoded from state and grant_id.
- Reset values: uart_tx_en=0, uart_tx_data=0, req_ready=0, grant_id=0, grant_active=0, err_timeout=0. The round-robin pointer resets to 0, the state to IDLE and the timeout counter to 0.
- Reset mid-operation returns to IDLE the next edge and drops any lock. An in-flight byte inside uart_tx is not cancelled by this block.

FSM states and transitions:
- IDLE: if any req_valid is set, pick the winner by round-robin starting at pointer, register grant_id, set grant_active=1, go to LOAD. Otherwise stay.
- LOAD: req_ready[grant_id]=1 for this single cycle. Capture req_data slice into uart_tx_data and req_last into last_r. Set uart_tx_en=1 registered. Go to START.
- START: uart_tx_en is high for exactly this cycle and is cleared at the exit edge. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY: if uart_tx_busy=1, go to WAIT_DONE. Else increment the counter; when the counter reaches BUSY_WAIT-1, pulse err_timeout, set grant_active=0, set pointer=grant_id+1 (mod NUM_REQ), go to IDLE.
- WAIT_DONE: when uart_tx_busy=0:
  - if last_r=1: grant_active=0, pointer=grant_id+1 mod NUM_REQ, go to IDLE;
  - else go to LOCKED.
- LOCKED: other requesters are ignored. If req_valid[grant_id]=1, go to LOAD; otherwise wait indefinitely.

Timing and arbitration rules:
- Latency: req_valid sampled in IDLE gives req_ready 1 cycle later and uart_tx_en 2 cycles later.
- Minimum per-byte overhead is 4 cycles plus the uart_tx busy time.
- Simultaneous requests: the lowest index at or above pointer wins, wrapping around. The winner rotates to the lowest priority after its packet ends.
- A requester that drops req_valid before req_ready violates protocol; behaviour is undefined and not checked.
- uart_tx_busy already high in START is treated as "busy seen" in WAIT_BUSY.

Decomposition:
- Package uart_pkg holds the state encoding (IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, LOCKED), DATA_W, and a clog2 helper constant function.
- Sub-module rr_arbiter: combinational round-robin selector.
  - Inputs: req vector, pointer.
  - Outputs: grant index, any.
  - Instantiated once.

Test Plan:
- Single byte: req_valid[2]=1, data 0x5A, last=1, with a uart_tx model raising busy 1 cycle after en for 10 cycles. Required: req_ready[2] 1 cycle after valid, uart_tx_en pulse 1 cycle later with data 0x5A, grant_active low after busy falls, pointer=3.
- Contention: req 0, 1 and 3 valid together, each a single-byte packet with last=1, pointer=0. Required: service order 0, 1, 3 and bytes appear in that order on uart_tx_data.
- Packet lock: req0 sends a 3-byte packet 0x11, 0x22, 0x33 (last on 0x33) while req1 holds 0x99 valid throughout. Required: 0x11, 0x22, 0x33 are sent contiguously, then 0x99; req_ready[1] never fires during req0's packet.
- Timeout: uart_tx_busy tied 0, req1 sends 0xAB. Required: err_timeout pulses exactly BUSY_WAIT cycles after START, FSM returns to IDLE, pointer=2.
- Reset mid-packet: assert rst for 1 cycle during WAIT_DONE of byte 2 of a 4-byte packet. Required: all outputs return to reset values next cycle and the next request is arbitrated from pointer 0.
- Fairness: requesters 0 and 1 continuously valid with single-byte packets, 8 packets. Required: strict alternation 0, 1, 0, 1, …

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    LOCKED
  } state_t;

  localparam int unsigned UART_DATA_W = 8;

  // Ceiling log2, never smaller than 1 so a 1-bit field always exists.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    int unsigned span;
    width = 0;
    span  = 1;
    while (span < value) begin
      span  = span << 1;
      width = width + 1;
    end
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester at or above ptr, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any
);

  // Scan NUM_REQ positions starting at ptr; the first active one wins.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    any   = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (!any && req[idx[ID_W-1:0]]) begin
        any   = 1'b1;
        grant = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx among NUM_REQ sources.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = UART_DATA_W,
  parameter int unsigned BUSY_WAIT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        uart_tx_en,
  output logic [DATA_W-1:0]           uart_tx_data,
  input  logic                        uart_tx_busy,
  output logic [clog2(NUM_REQ)-1:0]   grant_id,
  output logic                        grant_active,
  output logic                        err_timeout
);

  localparam int unsigned ID_W     = clog2(NUM_REQ);
  localparam int unsigned CNT_W    = clog2(BUSY_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_WAIT - 1);
  localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(NUM_REQ - 1);

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   next_ptr;
  logic [ID_W-1:0]   arb_grant;
  logic              arb_any;
  logic              last_r;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .any   (arb_any)
  );

  assign next_ptr = (grant_id == ID_MAX) ? '0 : grant_id + 1'b1;
  assign cnt_inc  = cnt + 1'b1;

  // Accept strobe goes to the owner only during the single LOAD cycle.
  always_comb begin
    req_ready = '0;
    if (state == LOAD) req_ready[grant_id] = 1'b1;
  end

  // Main sequencer: grant, load, start pulse, busy tracking and packet lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      err_timeout  <= 1'b0;
      last_r       <= 1'b0;
      cnt          <= '0;
    end else begin
      uart_tx_en  <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            grant_id     <= arb_grant;
            grant_active <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          uart_tx_data <= req_data[grant_id*DATA_W +: DATA_W];
          last_r       <= req_last[grant_id];
          uart_tx_en   <= 1'b1;
          state        <= START;
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (uart_tx_busy) begin
            state <= WAIT_DONE;
          end else begin
            // Compare the incremented value so the pulse lands BUSY_WAIT cycles after START.
            cnt <= cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              err_timeout  <= 1'b1;
              grant_active <= 1'b0;
              ptr          <= next_ptr;
              state        <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            if (last_r) begin
              grant_active <= 1'b0;
              ptr          <= next_ptr;
              state        <= IDLE;
            end else begin
              state <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (req_valid[grant_id]) state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
